// File: rtl/oser_frame_tx.sv
// oser_frame_tx: serializes four 16-bit channel words into 2-bit DDR lane
// nibbles plus an FCO nibble. Optional ramp source: OSER_TEST_PATTERN_EN.
module oser_frame_tx #(
  parameter int          NUM_CHAN  = 4,
  parameter logic [15:0] IDLE_WORD = 16'h0000
) (
  input  logic        data_clk,
  input  logic        data_rst,
  input  logic [15:0] chan_a,
  input  logic [15:0] chan_c,
  input  logic [15:0] chan_e,
  input  logic [15:0] chan_g,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic        sel_2lane,
  input  logic        sel_num_bits,
`ifdef OSER_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [1:0]  lane_a_nib,
  output logic [1:0]  lane_b_nib,
  output logic [1:0]  lane_c_nib,
  output logic [1:0]  lane_d_nib,
  output logic [1:0]  lane_e_nib,
  output logic [1:0]  lane_f_nib,
  output logic [1:0]  lane_g_nib,
  output logic [1:0]  lane_h_nib,
  output logic [1:0]  fco_nib,
  output logic        frame_start,
  output logic        underrun
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [2:0]  last;
  logic [3:0]  len;
  logic        m2, m12;
  logic        boundary, load, tm;
  logic [15:0] word [NUM_CHAN];
  logic [15:0] sr   [NUM_CHAN];
  logic [1:0]  lane [2*NUM_CHAN];

  assign word[0] = chan_a;
  assign word[1] = chan_c;
  assign word[2] = chan_e;
  assign word[3] = chan_g;

`ifdef OSER_TEST_PATTERN_EN
  logic [15:0] ramp [NUM_CHAN];
  assign tm = test_mode;
`else
  assign tm = 1'b0;
`endif

  // Frame length follows the mode latched for the frame in flight.
  always_comb begin
    last = 3'd7;
    unique case (1'b1)
      ( m12 &&  m2): last = 3'd2;
      ( m12 && !m2): last = 3'd5;
      (!m12 &&  m2): last = 3'd3;
      default:       last = 3'd7;
    endcase
  end

  assign len         = {1'b0, last} + 4'd1;
  assign boundary    = (state == RUN) && (cnt == last);
  assign load        = (state == IDLE) || boundary;
  assign frame_ready = !data_rst && load && !tm;

  // State register.
  always_ff @(posedge data_clk) begin
    if (data_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  // IDLE lasts exactly one cycle after reset release.
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = RUN;
  end

  // Nibble output, shift/load of channel words, frame counter, underrun.
  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      cnt         <= '0;
      m2          <= 1'b0;
      m12         <= 1'b0;
      fco_nib     <= 2'b00;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      for (int k = 0; k < NUM_CHAN; k++) begin
        sr[k]       <= '0;
        lane[2*k]   <= 2'b00;
        lane[2*k+1] <= 2'b00;
      end
    end else begin
      if (state == RUN) begin
        frame_start <= (cnt == 3'd0);
        fco_nib     <= {({cnt, 1'b0} < len), ({cnt, 1'b1} < len)};
        for (int k = 0; k < NUM_CHAN; k++) begin
          if (m2) begin
            lane[2*k]   <= {sr[k][15], sr[k][13]};
            lane[2*k+1] <= {sr[k][14], sr[k][12]};
            sr[k]       <= {sr[k][11:0], 4'b0000};
          end else begin
            lane[2*k]   <= sr[k][15:14];
            lane[2*k+1] <= 2'b00;
            sr[k]       <= {sr[k][13:0], 2'b00};
          end
        end
      end else begin
        frame_start <= 1'b0;
        fco_nib     <= 2'b00;
        for (int k = 0; k < NUM_CHAN; k++) begin
          lane[2*k]   <= 2'b00;
          lane[2*k+1] <= 2'b00;
        end
      end
      if (load) begin
        cnt <= '0;
        m2  <= sel_2lane;
        m12 <= sel_num_bits;
        for (int k = 0; k < NUM_CHAN; k++)
          sr[k] <= frame_valid ? word[k] : IDLE_WORD;
`ifdef OSER_TEST_PATTERN_EN
        if (tm)
          for (int k = 0; k < NUM_CHAN; k++) sr[k] <= ramp[k];
`endif
        if (boundary && !frame_valid && !tm) underrun <= 1'b1;
      end else begin
        cnt <= cnt + 3'd1;
      end
    end
  end

`ifdef OSER_TEST_PATTERN_EN
  // Per-channel ramp advances once per test frame.
  always_ff @(posedge data_clk) begin
    if (data_rst) begin
      for (int k = 0; k < NUM_CHAN; k++) ramp[k] <= 16'(k);
    end else if (load && tm) begin
      for (int k = 0; k < NUM_CHAN; k++)
        ramp[k] <= ramp[k] + (sel_num_bits ? 16'd16 : 16'd1);
    end
  end
`endif

  assign lane_a_nib = lane[0];
  assign lane_b_nib = lane[1];
  assign lane_c_nib = lane[2];
  assign lane_d_nib = lane[3];
  assign lane_e_nib = lane[4];
  assign lane_f_nib = lane[5];
  assign lane_g_nib = lane[6];
  assign lane_h_nib = lane[7];

endmodule

// File: tb/tb_oser_frame_tx.sv
// tb_oser_frame_tx: scoreboard bench for oser_frame_tx.
// Expected nibble streams are built from each accepted frame word.
module tb_oser_frame_tx;

  logic        clk = 1'b0;
  logic        data_rst;
  logic [15:0] chan_a, chan_c, chan_e, chan_g;
  logic        frame_valid, frame_ready;
  logic        sel_2lane, sel_num_bits;
  logic        test_mode;
  logic [1:0]  la, lb, lc, ld, le, lf, lg, lh, fco_nib;
  logic        frame_start, underrun;

  always #5 clk = ~clk;

  oser_frame_tx dut (
    .data_clk     (clk),
    .data_rst     (data_rst),
    .chan_a       (chan_a),
    .chan_c       (chan_c),
    .chan_e       (chan_e),
    .chan_g       (chan_g),
    .frame_valid  (frame_valid),
    .frame_ready  (frame_ready),
    .sel_2lane    (sel_2lane),
    .sel_num_bits (sel_num_bits),
`ifdef OSER_TEST_PATTERN_EN
    .test_mode    (test_mode),
`endif
    .lane_a_nib   (la),
    .lane_b_nib   (lb),
    .lane_c_nib   (lc),
    .lane_d_nib   (ld),
    .lane_e_nib   (le),
    .lane_f_nib   (lf),
    .lane_g_nib   (lg),
    .lane_h_nib   (lh),
    .fco_nib      (fco_nib),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  typedef struct packed {
    logic [15:0] lanes;
    logic [1:0]  fco;
    logic        fs;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          m_idle = 1'b1;
  int          m_pos = 0;
  int          m_len = 8;
  bit          exp_under = 1'b0;
  logic [15:0] m_ramp [4];

  // Builds the serial bit stream of one frame and pushes its nibbles.
  function automatic int push_frame(logic [15:0] w0, logic [15:0] w1,
                                    logic [15:0] w2, logic [15:0] w3,
                                    bit m2, bit m12);
    logic [15:0] ws [4];
    bit   ev [4][16];
    bit   od [4][16];
    int   nb, b, l;
    exp_t e;
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    nb = m12 ? 12 : 16;
    b  = m2 ? nb / 2 : nb;
    l  = b / 2;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 16; j++) begin
        ev[k][j] = 1'b0;
        od[k][j] = 1'b0;
      end
      for (int i = 0; i < nb; i++) begin
        if (!m2)        ev[k][i]   = ws[k][15-i];
        else if (i % 2) od[k][i/2] = ws[k][15-i];
        else            ev[k][i/2] = ws[k][15-i];
      end
    end
    for (int c = 0; c < l; c++) begin
      e     = '0;
      e.fs  = (c == 0);
      e.fco = {(2*c < b/2), (2*c+1 < b/2)};
      for (int k = 0; k < 4; k++) begin
        e.lanes[15-4*k -: 2] = {ev[k][2*c], ev[k][2*c+1]};
        e.lanes[13-4*k -: 2] = {od[k][2*c], od[k][2*c+1]};
      end
      q.push_back(e);
    end
    return l;
  endfunction

  // Compare outputs of the edge just past, then model the next edge.
  always @(negedge clk) begin
    exp_t        e, got;
    bit          bnd, tm, exp_ready;
    logic [15:0] w [4];
    got.lanes = {la, lb, lc, ld, le, lf, lg, lh};
    got.fco   = fco_nib;
    got.fs    = frame_start;
    e = (q.size() > 0) ? q.pop_front() : exp_t'(0);
    n_cmp++;
    assert (got === e) else begin
      n_bad++;
      $error("FAIL nibbles obs=%h exp=%h", got, e);
    end
    n_cmp++;
    assert (underrun === exp_under) else begin
      n_bad++;
      $error("FAIL underrun obs=%b exp=%b", underrun, exp_under);
    end
`ifdef OSER_TEST_PATTERN_EN
    tm = test_mode;
`else
    tm = 1'b0;
`endif
    exp_ready = 1'b0;
    if (data_rst) begin
      q.delete();
      m_idle    = 1'b1;
      m_pos     = 0;
      exp_under = 1'b0;
      for (int k = 0; k < 4; k++) m_ramp[k] = 16'(k);
    end else begin
      bnd       = m_idle || (m_pos == m_len - 1);
      exp_ready = bnd && !tm;
      if (bnd) begin
        if (m_idle) q.push_back(exp_t'(0));
        if (!m_idle && !frame_valid && !tm) exp_under = 1'b1;
        w[0] = frame_valid ? chan_a : 16'h0000;
        w[1] = frame_valid ? chan_c : 16'h0000;
        w[2] = frame_valid ? chan_e : 16'h0000;
        w[3] = frame_valid ? chan_g : 16'h0000;
        if (tm) begin
          for (int k = 0; k < 4; k++) begin
            w[k]      = m_ramp[k];
            m_ramp[k] = m_ramp[k] + (sel_num_bits ? 16'd16 : 16'd1);
          end
        end
        m_len  = push_frame(w[0], w[1], w[2], w[3],
                            sel_2lane, sel_num_bits);
        m_pos  = 0;
        m_idle = 1'b0;
      end else begin
        m_pos++;
      end
    end
    n_cmp++;
    assert (frame_ready === exp_ready) else begin
      n_bad++;
      $error("FAIL frame_ready obs=%b exp=%b", frame_ready, exp_ready);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    data_rst     = 1'b1;
    frame_valid  = 1'b1;
    chan_a       = 16'hA5C3;
    chan_c       = 16'h1234;
    chan_e       = 16'h8001;
    chan_g       = 16'hFFFF;
    sel_2lane    = 1'b0;
    sel_num_bits = 1'b0;
    test_mode    = 1'b0;
    cyc(3);
    data_rst = 1'b0;
    cyc(24);
    sel_2lane = 1'b1;
    chan_a    = 16'hFF00;
    cyc(12);
    sel_num_bits = 1'b1;
    chan_a       = 16'hABC7;
    chan_c       = 16'h5A5F;
    cyc(9);
    frame_valid = 1'b0;
    cyc(3);
    frame_valid = 1'b1;
    cyc(9);
    sel_2lane    = 1'b0;
    sel_num_bits = 1'b0;
    cyc(10);
    sel_num_bits = 1'b1;
    cyc(2);
    sel_num_bits = 1'b0;
    cyc(11);
    data_rst = 1'b1;
    cyc(2);
    data_rst = 1'b0;
    cyc(12);
    for (int i = 0; i < 80; i++) begin
      chan_a       = 16'($urandom);
      chan_c       = 16'($urandom);
      chan_e       = 16'($urandom);
      chan_g       = 16'($urandom);
      frame_valid  = ($urandom_range(0, 7) != 0);
      sel_2lane    = 1'($urandom_range(0, 1));
      sel_num_bits = 1'($urandom_range(0, 1));
      cyc(1);
    end
    frame_valid = 1'b1;
`ifdef OSER_TEST_PATTERN_EN
    data_rst = 1'b1;
    cyc(2);
    data_rst     = 1'b0;
    sel_2lane    = 1'b0;
    sel_num_bits = 1'b0;
    test_mode    = 1'b1;
    cyc(30);
    sel_num_bits = 1'b1;
    cyc(20);
    test_mode = 1'b0;
    cyc(12);
`endif
    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
